// File: rtl/bmb_hakem_pkg.sv
// Shared types and constants for the Zba unit arbiter: komut bit layout,
// requester ID type and the packed operation word sent to the unit.
package bmb_hakem_pkg;

   localparam int BMB_XLEN = 32;
   localparam int KOMUT_W  = 9;

   // Position of each instruction bit inside komut, MSB first {30,27,26,25,14,13,12,5,3}.
   localparam int KOMUT_B30 = 8;
   localparam int KOMUT_B27 = 7;
   localparam int KOMUT_B26 = 6;
   localparam int KOMUT_B25 = 5;
   localparam int KOMUT_B14 = 4;
   localparam int KOMUT_B13 = 3;
   localparam int KOMUT_B12 = 2;
   localparam int KOMUT_B5  = 1;
   localparam int KOMUT_B3  = 0;

   typedef logic istek_id_t;

   typedef struct packed {
      logic [BMB_XLEN-1:0] deger1;
      logic [BMB_XLEN-1:0] deger2;
      logic [BMB_XLEN-1:0] deger3;
      logic [KOMUT_W-1:0]  komut;
   } bmb_istek_t;

   function automatic istek_id_t diger_istek(input istek_id_t id);
      return ~id;
   endfunction

   function automatic logic [KOMUT_W-1:0] komut_paketle(
      input logic b30, input logic b27, input logic b26,
      input logic b25, input logic b14, input logic b13,
      input logic b12, input logic b5,  input logic b3
   );
      logic [KOMUT_W-1:0] k;
      k            = '0;
      k[KOMUT_B30] = b30;
      k[KOMUT_B27] = b27;
      k[KOMUT_B26] = b26;
      k[KOMUT_B25] = b25;
      k[KOMUT_B14] = b14;
      k[KOMUT_B13] = b13;
      k[KOMUT_B12] = b12;
      k[KOMUT_B5]  = b5;
      k[KOMUT_B3]  = b3;
      return k;
   endfunction

endpackage

// File: rtl/bmb_etiket_fifo.sv
// In-order tag FIFO holding the requester ID of every issued operation.
// Head is read combinationally; push and pop may happen in the same cycle, even when full.
module bmb_etiket_fifo
   import bmb_hakem_pkg::*;
#(
   parameter int DERINLIK = 4
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      push_i,
   input  istek_id_t push_id_i,
   input  logic      pop_i,
   output istek_id_t bas_o,
   output logic      bos_o,
   output logic      dolu_o
);

   localparam int PW = $clog2(DERINLIK);
   localparam logic [PW-1:0] PTR_BIR    = 1;
   localparam logic [PW:0]   SAYAC_BIR  = 1;
   localparam logic [PW:0]   SAYAC_DOLU = DERINLIK[PW:0];

   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [PW:0]   sayac_q, sayac_d;
   istek_id_t     mem_q [DERINLIK];
   istek_id_t     mem_d [DERINLIK];
   logic          push_ok;
   logic          pop_ok;

   assign bos_o  = (sayac_q == '0);
   assign dolu_o = (sayac_q == SAYAC_DOLU);
   assign bas_o  = mem_q[rd_q];

   // A pop frees a slot in the same cycle, so push while full is legal alongside it.
   assign pop_ok  = pop_i && !bos_o;
   assign push_ok = push_i && (!dolu_o || pop_ok);

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      sayac_d = sayac_q;
      mem_d   = mem_q;
      if (push_ok) begin
         mem_d[wr_q] = push_id_i;
         wr_d        = wr_q + PTR_BIR;
      end
      if (pop_ok) begin
         rd_d = rd_q + PTR_BIR;
      end
      case ({push_ok, pop_ok})
         2'b10:   sayac_d = sayac_q + SAYAC_BIR;
         2'b01:   sayac_d = sayac_q - SAYAC_BIR;
         default: sayac_d = sayac_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         sayac_q <= '0;
         for (int i = 0; i < DERINLIK; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         sayac_q <= sayac_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: rtl/bit_manipulasyon_hakemi.sv
// Two-requester arbiter in front of one Zba unit: registered issue, in-order tag FIFO,
// combinational result steering. Define BMB_HAKEM_SABIT_ONCELIK_EN for fixed priority (requester 0).
module bit_manipulasyon_hakemi
   import bmb_hakem_pkg::*;
#(
   parameter int XLEN            = 32,
   parameter int ETIKET_DERINLIK = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,

   input  logic               istek0_valid_i,
   output logic               istek0_ready_o,
   input  logic [XLEN-1:0]    istek0_deger1_i,
   input  logic [XLEN-1:0]    istek0_deger2_i,
   input  logic [XLEN-1:0]    istek0_deger3_i,
   input  logic [KOMUT_W-1:0] istek0_komut_i,

   input  logic               istek1_valid_i,
   output logic               istek1_ready_o,
   input  logic [XLEN-1:0]    istek1_deger1_i,
   input  logic [XLEN-1:0]    istek1_deger2_i,
   input  logic [XLEN-1:0]    istek1_deger3_i,
   input  logic [KOMUT_W-1:0] istek1_komut_i,

   output logic               bmb_din_valid_o,
   input  logic               bmb_din_ready_i,
   output logic [XLEN-1:0]    bmb_deger1_o,
   output logic [XLEN-1:0]    bmb_deger2_o,
   output logic [XLEN-1:0]    bmb_deger3_o,
   output logic [KOMUT_W-1:0] bmb_komut_o,

   input  logic               bmb_dout_valid_i,
   output logic               bmb_dout_ready_o,
   input  logic [XLEN-1:0]    bmb_dout_result_i,

   output logic               yanit0_valid_o,
   input  logic               yanit0_ready_i,
   output logic [XLEN-1:0]    yanit0_result_o,
   output logic               yanit1_valid_o,
   input  logic               yanit1_ready_i,
   output logic [XLEN-1:0]    yanit1_result_o,

   output logic               hata_o
);

   // The operation word width is fixed by the package; XLEN must match BMB_XLEN.
   bmb_istek_t cikis_q, cikis_d;
   logic       cikis_gecerli_q, cikis_gecerli_d;
   logic       hata_q, hata_d;

   istek_id_t  fifo_bas;
   logic       fifo_bos;
   logic       fifo_dolu;
   logic       etiket_pop;

   logic       cikis_bos;
   logic       etiket_yer;
   logic       hibe;
   istek_id_t  kazanan;

   bmb_etiket_fifo #(
      .DERINLIK (ETIKET_DERINLIK)
   ) u_etiket_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (hibe),
      .push_id_i (kazanan),
      .pop_i     (etiket_pop),
      .bas_o     (fifo_bas),
      .bos_o     (fifo_bos),
      .dolu_o    (fifo_dolu)
   );

   // Results go to the head tag; with no tag outstanding they are accepted and dropped.
   always_comb begin
      yanit0_valid_o   = 1'b0;
      yanit1_valid_o   = 1'b0;
      yanit0_result_o  = bmb_dout_result_i;
      yanit1_result_o  = bmb_dout_result_i;
      bmb_dout_ready_o = 1'b1;
      if (!fifo_bos) begin
         if (fifo_bas == 1'b0) begin
            yanit0_valid_o   = bmb_dout_valid_i;
            bmb_dout_ready_o = yanit0_ready_i;
         end else begin
            yanit1_valid_o   = bmb_dout_valid_i;
            bmb_dout_ready_o = yanit1_ready_i;
         end
      end
   end

   assign etiket_pop = bmb_dout_valid_i && bmb_dout_ready_o && !fifo_bos;
   assign cikis_bos  = !cikis_gecerli_q || bmb_din_ready_i;
   assign etiket_yer = !fifo_dolu || etiket_pop;
   assign hibe       = !rst_i && cikis_bos && etiket_yer && (istek0_valid_i || istek1_valid_i);

`ifdef BMB_HAKEM_SABIT_ONCELIK_EN
   assign kazanan = istek0_valid_i ? 1'b0 : 1'b1;
`else
   istek_id_t oncelik_q, oncelik_d;

   assign kazanan   = (istek0_valid_i && istek1_valid_i) ? oncelik_q : istek1_valid_i;
   assign oncelik_d = hibe ? diger_istek(kazanan) : oncelik_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         oncelik_q <= 1'b0;
      end else begin
         oncelik_q <= oncelik_d;
      end
   end
`endif

   assign istek0_ready_o = hibe && (kazanan == 1'b0);
   assign istek1_ready_o = hibe && (kazanan == 1'b1);

   always_comb begin
      cikis_d         = cikis_q;
      cikis_gecerli_d = cikis_gecerli_q;
      if (hibe) begin
         cikis_gecerli_d = 1'b1;
         if (kazanan == 1'b0) begin
            cikis_d.deger1 = istek0_deger1_i;
            cikis_d.deger2 = istek0_deger2_i;
            cikis_d.deger3 = istek0_deger3_i;
            cikis_d.komut  = istek0_komut_i;
         end else begin
            cikis_d.deger1 = istek1_deger1_i;
            cikis_d.deger2 = istek1_deger2_i;
            cikis_d.deger3 = istek1_deger3_i;
            cikis_d.komut  = istek1_komut_i;
         end
      end else if (bmb_din_ready_i) begin
         cikis_gecerli_d = 1'b0;
      end
      hata_d = hata_q || (bmb_dout_valid_i && fifo_bos);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cikis_q         <= '0;
         cikis_gecerli_q <= 1'b0;
         hata_q          <= 1'b0;
      end else begin
         cikis_q         <= cikis_d;
         cikis_gecerli_q <= cikis_gecerli_d;
         hata_q          <= hata_d;
      end
   end

   assign bmb_din_valid_o = cikis_gecerli_q;
   assign bmb_deger1_o    = cikis_q.deger1;
   assign bmb_deger2_o    = cikis_q.deger2;
   assign bmb_deger3_o    = cikis_q.deger3;
   assign bmb_komut_o     = cikis_q.komut;
   assign hata_o          = hata_q;

endmodule

// File: tb/tb_bit_manipulasyon_hakemi.sv
// Bench for bit_manipulasyon_hakemi: directed scenarios then randomized traffic, all
// checked cycle by cycle against a queue-based reference model with a Zba unit stub.
module tb_bit_manipulasyon_hakemi;
   import bmb_hakem_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic               v0, v1;
   logic [XLEN-1:0]    a0_1, a0_2, a0_3, a1_1, a1_2, a1_3;
   logic [KOMUT_W-1:0] k0, k1;
   logic               din_ready, dout_valid, y0_ready, y1_ready;
   logic [XLEN-1:0]    dout_result;

   logic               istek0_ready_o, istek1_ready_o, bmb_din_valid_o, bmb_dout_ready_o;
   logic [XLEN-1:0]    bmb_deger1_o, bmb_deger2_o, bmb_deger3_o;
   logic [KOMUT_W-1:0] bmb_komut_o;
   logic               yanit0_valid_o, yanit1_valid_o, hata_o;
   logic [XLEN-1:0]    yanit0_result_o, yanit1_result_o;

   bit_manipulasyon_hakemi #(.XLEN(XLEN), .ETIKET_DERINLIK(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst),
      .istek0_valid_i(v0), .istek0_ready_o(istek0_ready_o),
      .istek0_deger1_i(a0_1), .istek0_deger2_i(a0_2), .istek0_deger3_i(a0_3), .istek0_komut_i(k0),
      .istek1_valid_i(v1), .istek1_ready_o(istek1_ready_o),
      .istek1_deger1_i(a1_1), .istek1_deger2_i(a1_2), .istek1_deger3_i(a1_3), .istek1_komut_i(k1),
      .bmb_din_valid_o(bmb_din_valid_o), .bmb_din_ready_i(din_ready),
      .bmb_deger1_o(bmb_deger1_o), .bmb_deger2_o(bmb_deger2_o), .bmb_deger3_o(bmb_deger3_o),
      .bmb_komut_o(bmb_komut_o),
      .bmb_dout_valid_i(dout_valid), .bmb_dout_ready_o(bmb_dout_ready_o),
      .bmb_dout_result_i(dout_result),
      .yanit0_valid_o(yanit0_valid_o), .yanit0_ready_i(y0_ready), .yanit0_result_o(yanit0_result_o),
      .yanit1_valid_o(yanit1_valid_o), .yanit1_ready_i(y1_ready), .yanit1_result_o(yanit1_result_o),
      .hata_o(hata_o)
   );

   // reference model state
   int              tag_q[$];
   logic [XLEN-1:0] unit_q[$];
   int              grant_log[$];
   int              resp_log[$];
   logic [XLEN-1:0] exp_q[$];
   bit              m_valid, m_pri, m_hata;
   logic [XLEN-1:0] m_d1, m_d2, m_d3;
   logic [KOMUT_W-1:0] m_k;
   bit              e_grant, e_win, e_pop, e_head_ok, e_dr, stub_src;
   int              e_head;
   int              n_cmp, n_err;

   // scoreboard
   task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // unit stub: offers the oldest accepted result when enabled
   task automatic stub(input bit en);
      stub_src    = en && (unit_q.size() > 0);
      dout_valid  = stub_src;
      dout_result = stub_src ? unit_q[0] : $urandom;
   endtask

   task automatic rand_operands();
      a0_1 = $urandom; a0_2 = $urandom; a0_3 = $urandom; k0 = KOMUT_W'($urandom);
      a1_1 = $urandom; a1_2 = $urandom; a1_3 = $urandom; k1 = KOMUT_W'($urandom);
   endtask

   task automatic settle();
      bit free_o, room;
      #1;
      e_head_ok = tag_q.size() > 0;
      e_head    = e_head_ok ? tag_q[0] : 0;
      e_dr      = !e_head_ok ? 1'b1 : (e_head == 0 ? y0_ready : y1_ready);
      e_pop     = e_head_ok && dout_valid && e_dr;
      free_o    = !m_valid || din_ready;
      room      = (tag_q.size() < DEPTH) || e_pop;
      e_grant   = !rst && free_o && room && (v0 || v1);
`ifdef BMB_HAKEM_SABIT_ONCELIK_EN
      e_win = !v0;
`else
      e_win = (v0 && v1) ? m_pri : v1;
`endif
      check_eq("istek0_ready", istek0_ready_o, e_grant && !e_win);
      check_eq("istek1_ready", istek1_ready_o, e_grant && e_win);
      check_eq("dout_ready", bmb_dout_ready_o, e_dr);
      check_eq("yanit0_valid", yanit0_valid_o, e_head_ok && e_head == 0 && dout_valid);
      check_eq("yanit1_valid", yanit1_valid_o, e_head_ok && e_head == 1 && dout_valid);
      if (e_head_ok && dout_valid) begin
         if (e_head == 0) check_eq("yanit0_result", yanit0_result_o, dout_result);
         else             check_eq("yanit1_result", yanit1_result_o, dout_result);
      end
      check_eq("din_valid", bmb_din_valid_o, m_valid);
      if (m_valid) begin
         check_eq("deger1", bmb_deger1_o, m_d1);
         check_eq("deger2", bmb_deger2_o, m_d2);
         check_eq("deger3", bmb_deger3_o, m_d3);
         check_eq("komut", bmb_komut_o, m_k);
      end
      check_eq("hata", hata_o, m_hata);
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         tag_q.delete();
         m_valid = 0; m_pri = 0; m_hata = 0;
         m_d1 = '0; m_d2 = '0; m_d3 = '0; m_k = '0;
      end else begin
         if (dout_valid && !e_head_ok) m_hata = 1;
         if (stub_src && dout_valid && e_dr) void'(unit_q.pop_front());
         if (e_pop) begin
            resp_log.push_back(e_head);
            void'(tag_q.pop_front());
         end
         if (m_valid && din_ready) unit_q.push_back((m_d1 << 1) + m_d2);
         if (e_grant) begin
            tag_q.push_back(e_win);
            grant_log.push_back(e_win);
            m_valid = 1;
            m_pri   = !e_win;
            if (e_win) begin m_d1 = a1_1; m_d2 = a1_2; m_d3 = a1_3; m_k = k1; end
            else       begin m_d1 = a0_1; m_d2 = a0_2; m_d3 = a0_3; m_k = k0; end
         end else if (din_ready) begin
            m_valid = 0;
         end
      end
      #1;
   endtask

   task automatic cyc();
      settle();
      advance();
   endtask

   task automatic do_reset();
      rst = 1; v0 = 0; v1 = 0; din_ready = 1; y0_ready = 1; y1_ready = 1;
      stub_src = 0; dout_valid = 0;
      advance();
      settle();
      check_eq("rst_hata", hata_o, 1'b0);
      check_eq("rst_din_valid", bmb_din_valid_o, 1'b0);
      check_eq("rst_y0_valid", yanit0_valid_o, 1'b0);
      check_eq("rst_y1_valid", yanit1_valid_o, 1'b0);
      advance();
      rst = 0;
      unit_q.delete(); grant_log.delete(); resp_log.delete();
   endtask

   initial begin
      logic [XLEN-1:0] hold_d1;
      n_cmp = 0; n_err = 0;
      rst = 1; v0 = 0; v1 = 0; din_ready = 1; y0_ready = 1; y1_ready = 1;
      dout_valid = 0; dout_result = '0; stub_src = 0;
      rand_operands();

      // reset state
      advance();
      settle();
      check_eq("rst_istek0_ready", istek0_ready_o, 1'b0);
      check_eq("rst_istek1_ready", istek1_ready_o, 1'b0);
      check_eq("rst_din_valid", bmb_din_valid_o, 1'b0);
      check_eq("rst_deger1", bmb_deger1_o, '0);
      check_eq("rst_deger2", bmb_deger2_o, '0);
      check_eq("rst_deger3", bmb_deger3_o, '0);
      check_eq("rst_komut", bmb_komut_o, '0);
      check_eq("rst_hata", hata_o, 1'b0);
      advance();
      rst = 0;

      // single issue: SH1ADD 4,1 -> 9 on yanit0
      v0 = 1; a0_1 = 4; a0_2 = 1; a0_3 = 0;
      k0 = komut_paketle(0, 0, 0, 0, 0, 1, 0, 1, 0);
      stub(0);
      settle();
      check_eq("t1_istek0_ready", istek0_ready_o, 1'b1);
      advance();
      v0 = 0; stub(0);
      settle();
      check_eq("t1_din_valid", bmb_din_valid_o, 1'b1);
      check_eq("t1_deger1", bmb_deger1_o, 4);
      advance();
      stub(1);
      settle();
      check_eq("t1_yanit0_result", yanit0_result_o, 9);
      check_eq("t1_yanit0_valid", yanit0_valid_o, 1'b1);
      check_eq("t1_yanit1_valid", yanit1_valid_o, 1'b0);
      advance();

      // contention: both valid for 4 cycles
      do_reset();
`ifdef BMB_HAKEM_SABIT_ONCELIK_EN
      exp_q = '{0, 0, 0, 0};
`else
      exp_q = '{0, 1, 0, 1};
`endif
      v0 = 1; v1 = 1;
      for (int i = 0; i < 4; i++) begin rand_operands(); stub(1); cyc(); end
      v0 = 0; v1 = 0;
      for (int i = 0; i < 6; i++) begin stub(1); cyc(); end
      check_eq("cont_n_grants", grant_log.size(), 4);
      check_eq("cont_n_resps", resp_log.size(), 4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++) check_eq("cont_grant", grant_log[i], exp_q[i]);
      for (int i = 0; i < 4 && i < resp_log.size(); i++) check_eq("cont_resp", resp_log[i], exp_q[i]);

      // backpressure on the unit input
      do_reset();
      v0 = 1; v1 = 1; rand_operands(); stub(0);
      cyc();
      hold_d1 = m_d1;
      din_ready = 0;
      for (int i = 0; i < 3; i++) begin
         rand_operands(); stub(0);
         settle();
         check_eq("bp_istek0_ready", istek0_ready_o, 1'b0);
         check_eq("bp_istek1_ready", istek1_ready_o, 1'b0);
         check_eq("bp_deger1_stable", bmb_deger1_o, hold_d1);
         advance();
      end
      din_ready = 1; rand_operands(); stub(0);
      settle();
      check_eq("bp_resume", istek0_ready_o || istek1_ready_o, 1'b1);
      advance();

      // tag FIFO full, then pop and grant in the same cycle
      do_reset();
      v0 = 1; v1 = 0;
      for (int i = 0; i < 4; i++) begin rand_operands(); stub(0); cyc(); end
      stub(0);
      settle();
      check_eq("full_istek0_ready", istek0_ready_o, 1'b0);
      check_eq("full_istek1_ready", istek1_ready_o, 1'b0);
      advance();
      stub(1);
      settle();
      check_eq("full_pop_grant", istek0_ready_o, 1'b1);
      advance();
      v0 = 0;

      // response stall with head = 1
      do_reset();
      v1 = 1; rand_operands(); stub(0); cyc();
      v1 = 0; stub(0); cyc();
      y1_ready = 0;
      for (int i = 0; i < 3; i++) begin
         stub(1);
         settle();
         check_eq("stall_dout_ready", bmb_dout_ready_o, 1'b0);
         check_eq("stall_yanit1_valid", yanit1_valid_o, 1'b1);
         advance();
      end
      y1_ready = 1; stub(1);
      settle();
      check_eq("stall_release", bmb_dout_ready_o, 1'b1);
      advance();

      // protocol error: result with no outstanding tag
      do_reset();
      stub_src = 0; dout_valid = 1; dout_result = $urandom;
      settle();
      advance();
      dout_valid = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check_eq("err_hata_sticky", hata_o, 1'b1);
         advance();
      end
      do_reset();

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         rst       = ($urandom_range(0, 99) == 0);
         v0        = ($urandom_range(0, 2) != 0);
         v1        = ($urandom_range(0, 2) != 0);
         din_ready = ($urandom_range(0, 3) != 0);
         y0_ready  = ($urandom_range(0, 3) != 0);
         y1_ready  = ($urandom_range(0, 3) != 0);
         rand_operands();
         stub($urandom_range(0, 2) != 0);
         cyc();
      end
      rst = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
